// File: rtl/div_nonrestoring.sv
// Iterative signed divider: shifts a {remainder,quotient} register left one bit per cycle
// using non-restoring add/subtract on |A|/|B|, then applies sign and exception overrides.
module div_nonrestoring #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2*WIDTH:0] rq_q, rq_d;
    logic [WIDTH:0]   div_q, div_d;
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH-1:0] abs_a, abs_b, quo;
    logic [2*WIDTH:0] rq_sh;
    logic [WIDTH:0]   r_new;

    always_comb begin
        abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        rq_sh = {rq_q[2*WIDTH-1:0], 1'b0};
        // The sign of the pre-shift partial remainder selects subtract vs. add-back
        r_new = rq_q[2*WIDTH] ? (rq_sh[2*WIDTH:WIDTH] + div_q)
                              : (rq_sh[2*WIDTH:WIDTH] - div_q);
        quo   = rq_q[WIDTH-1:0];

        state_d  = state_q;
        count_d  = count_q;
        rq_d     = rq_q;
        div_d    = div_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        if (ctrl_DIV) begin
            neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_d   = {1'b0, abs_b};
            rq_d    = {{(WIDTH+1){1'b0}}, abs_a};
            count_d = '0;
            dz_d    = (data_operandB == '0);
            ovf_d   = (data_operandA == MIN) && (data_operandB == '1);
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    rq_d    = {r_new, rq_sh[WIDTH-1:1], ~r_new[WIDTH]};
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(WIDTH-1)) state_d = FIX;
                end
                FIX: begin
                    if (dz_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else if (ovf_q) begin
                        result_d = MIN;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = neg_q ? -quo : quo;
                        exc_d    = 1'b0;
                    end
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rq_q     <= '0;
            div_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rq_q     <= rq_d;
            div_q    <= div_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
endmodule
